cond_logic: RTL and testbench
=============================

COND_LOGIC -- requirements
Module: cond_logic

Interface
REQ-001 The block SHALL be single-clock with synchronous, active-low reset, in the port order given below.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  in  1  synchronous active-low reset.
REQ-004 En  in  1  instruction-valid or advance qualifier; 0 = bubble or stall cycle.
REQ-005 Cond  in  4  instruction condition field, Instr[31:28].
REQ-006 ALUFlags  in  4  current-cycle ALU result flags {N,Z,C,V}, bit 3 = N.
REQ-007 FlagW  in  2  flag-write request from the decoder; [1] = N,Z group, [0] = C,V group.
REQ-008 PCS  in  1  decoder request to write the PC (branch, or Rd = R15).
REQ-009 RegW  in  1  decoder register-write request.
REQ-010 MemW  in  1  decoder memory-write request.
REQ-011 PCSrc  out  1  gated PC-select: PCS & CondEx & En.
REQ-012 RegWrite  out  1  gated register write: RegW & CondEx & En.
REQ-013 MemWrite  out  1  gated memory write: MemW & CondEx & En.
REQ-014 CondEx  out  1  condition-pass for the current instruction.
REQ-015 Flags  out  4  architectural flag register {N,Z,C,V}, registered.

Function
REQ-016 CondEx SHALL be combinational from Cond and the registered Flags, never from ALUFlags.
REQ-017 Condition table: 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V.
REQ-018 Condition table continued: 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 treated as 1.
REQ-019 On a rising edge with reset_n=1, En=1, CondEx=1 and FlagW[1]=1, Flags[3:2] SHALL load ALUFlags[3:2].
REQ-020 On a rising edge with reset_n=1, En=1, CondEx=1 and FlagW[0]=1, Flags[1:0] SHALL load ALUFlags[1:0].
REQ-021 The two flag groups SHALL update independently; a group not enabled SHALL hold its value.
REQ-022 Flag update latency is one cycle: flags written in cycle n SHALL govern CondEx from cycle n+1.
REQ-023 A failed condition (CondEx=0) SHALL suppress all flag updates and force PCSrc, RegWrite and MemWrite to 0 in that cycle.
REQ-024 When En=0, Flags SHALL hold and PCSrc, RegWrite and MemWrite SHALL be 0; CondEx still reflects Cond and Flags.
REQ-025 The block SHALL perform no arithmetic; X or Z on FlagW while En=0 SHALL NOT disturb Flags.

Reset
REQ-026 While reset_n=0 at a rising edge, Flags SHALL become 4'b0000 on that edge, overriding any simultaneous flag write.
REQ-027 While reset_n=0, PCSrc, RegWrite and MemWrite SHALL be 0 regardless of other inputs.
REQ-028 After reset, with Flags=0: EQ fails, NE passes, GE passes, and AL passes.
REQ-029 If reset is asserted mid-stream, the in-flight instruction's writes SHALL be suppressed and no partial flag state SHALL survive.

Structure
REQ-030 A shared package SHALL hold the 4-bit condition-code constants (EQ through AL) and the flag bit indices N=3, Z=2, C=1, V=0.
REQ-031 The condition evaluation SHALL be a combinational sub-module, cond_check (inputs Cond and Flags, output CondEx).
REQ-032 The flag register and output gating SHALL live in cond_logic.

Verification
REQ-033 Reset: reset_n=0 for 2 cycles with FlagW=11, En=1, ALUFlags=1111 -> Flags=0000, RegWrite=0; release -> Cond=0001 gives CondEx=1.
REQ-034 CMP then BEQ: cycle 1 Cond=1110, FlagW=11, ALUFlags=0110 -> cycle 2 Flags=0110; cycle 2 Cond=0000, PCS=1 -> PCSrc=1.
REQ-035 Split groups: Flags=0000, FlagW=10, ALUFlags=1111 -> Flags=1100; then FlagW=01, ALUFlags=0000 -> Flags=1100.
REQ-036 Failed condition: Flags=0100, Cond=0001, RegW=1, MemW=1, FlagW=11 -> RegWrite=0, MemWrite=0, Flags unchanged at 0100.
REQ-037 Signed conditions: Flags=1000 (N!=V) -> LT=1, GE=0, GT=0, LE=1; Flags=1001 -> GE=1, GT=1; Flags=0010 -> HI=1, LS=0.
REQ-038 Stall: En=0, Cond=1110, RegW=1, FlagW=11, ALUFlags=1111 -> RegWrite=0, Flags held; En=1 next cycle -> RegWrite=1.

Source files
------------

// File: rtl/cond_logic_pkg.sv
// Shared definitions for the conditional-execution block: condition codes
// and the bit positions of the {N,Z,C,V} flags.
package cond_logic_pkg;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int FLAGS_W = 4;
    localparam int COND_W  = 4;

    typedef enum logic [COND_W-1:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

endpackage

// File: rtl/cond_logic_cond_check.sv
// Purely combinational condition evaluator: decides whether an instruction
// with condition field Cond executes given the architectural flags.
module cond_check
    import cond_logic_pkg::*;
(
    input  logic [COND_W-1:0]  Cond,
    input  logic [FLAGS_W-1:0] Flags,
    output logic               CondEx
);

    logic n_flag;
    logic z_flag;
    logic c_flag;
    logic v_flag;
    logic signed_ge;

    assign n_flag    = Flags[FLAG_N];
    assign z_flag    = Flags[FLAG_Z];
    assign c_flag    = Flags[FLAG_C];
    assign v_flag    = Flags[FLAG_V];
    assign signed_ge = (n_flag == v_flag);

    always_comb begin
        CondEx = 1'b1;
        case (cond_e'(Cond))
            COND_EQ: CondEx = z_flag;
            COND_NE: CondEx = ~z_flag;
            COND_CS: CondEx = c_flag;
            COND_CC: CondEx = ~c_flag;
            COND_MI: CondEx = n_flag;
            COND_PL: CondEx = ~n_flag;
            COND_VS: CondEx = v_flag;
            COND_VC: CondEx = ~v_flag;
            COND_HI: CondEx = c_flag & ~z_flag;
            COND_LS: CondEx = ~c_flag | z_flag;
            COND_GE: CondEx = signed_ge;
            COND_LT: CondEx = ~signed_ge;
            COND_GT: CondEx = ~z_flag & signed_ge;
            COND_LE: CondEx = z_flag | ~signed_ge;
            COND_AL: CondEx = 1'b1;
            // The unused encoding executes unconditionally, like AL.
            COND_NV: CondEx = 1'b1;
            default: CondEx = 1'b1;
        endcase
    end

endmodule

// File: rtl/cond_logic.sv
// Conditional-execution unit: holds the architectural flag register and
// gates the decoder's write requests with the condition result.
module cond_logic
    import cond_logic_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               En,
    input  logic [COND_W-1:0]  Cond,
    input  logic [FLAGS_W-1:0] ALUFlags,
    input  logic [1:0]         FlagW,
    input  logic               PCS,
    input  logic               RegW,
    input  logic               MemW,
    output logic               PCSrc,
    output logic               RegWrite,
    output logic               MemWrite,
    output logic               CondEx,
    output logic [FLAGS_W-1:0] Flags
);

    logic [FLAGS_W-1:0] flags_q;
    logic               cond_ex;
    logic               issue;
    logic               write_nz;
    logic               write_cv;

    // The condition sees only the registered flags, so a flag-setting
    // instruction influences the next instruction, never itself.
    cond_check u_cond_check (
        .Cond   (Cond),
        .Flags  (flags_q),
        .CondEx (cond_ex)
    );

    // Reset is folded into the qualifier so nothing escapes during reset.
    assign issue    = reset_n & En & cond_ex;
    assign write_nz = issue & FlagW[1];
    assign write_cv = issue & FlagW[0];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            flags_q <= '0;
        end else begin
            if (write_nz) begin
                flags_q[FLAG_N:FLAG_Z] <= ALUFlags[FLAG_N:FLAG_Z];
            end
            if (write_cv) begin
                flags_q[FLAG_C:FLAG_V] <= ALUFlags[FLAG_C:FLAG_V];
            end
        end
    end

    assign PCSrc    = issue & PCS;
    assign RegWrite = issue & RegW;
    assign MemWrite = issue & MemW;
    assign CondEx   = cond_ex;
    assign Flags    = flags_q;

endmodule

// File: tb/tb_cond_logic.sv
// Self-checking bench for cond_logic: a reference model predicts outputs and
// flags, which are queued at drive time and compared as the DUT responds.
module tb_cond_logic;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       En;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS;
    logic       RegW;
    logic       MemW;
    logic       PCSrc;
    logic       RegWrite;
    logic       MemWrite;
    logic       CondEx;
    logic [3:0] Flags;

    int assertCount = 0;
    int failCount   = 0;

    typedef struct {
        string tag;
        bit    checkCx;
        logic  cx;
        logic  pcsrc;
        logic  regwrite;
        logic  memwrite;
    } comb_exp_t;

    typedef struct {
        string      tag;
        logic [3:0] flags;
    } flag_exp_t;

    comb_exp_t  combQ[$];
    flag_exp_t  flagQ[$];
    logic [3:0] modelFlags = 4'bxxxx;
    bit         modelValid = 1'b0;

    always #5 clk = ~clk;

    cond_logic dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .En       (En),
        .Cond     (Cond),
        .ALUFlags (ALUFlags),
        .FlagW    (FlagW),
        .PCS      (PCS),
        .RegW     (RegW),
        .MemW     (MemW),
        .PCSrc    (PCSrc),
        .RegWrite (RegWrite),
        .MemWrite (MemWrite),
        .CondEx   (CondEx),
        .Flags    (Flags)
    );

    // Reference uses the odd/even pairing: odd codes invert the even test.
    function automatic logic modelCond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, base;
        n  = f[3];
        z  = f[2];
        cf = f[1];
        v  = f[0];
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cf;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cf & ~z;
            3'd5:    base = (n == v);
            3'd6:    base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        if (c[3:1] == 3'd7) return 1'b1;
        return base ^ c[0];
    endfunction

    task automatic checkOutput(input string tag, input logic [3:0] observed,
                               input logic [3:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %b, expected %b", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rn, input logic en, input logic [3:0] cond,
                                 input logic [3:0] alu, input logic [1:0] fw,
                                 input logic pcs, input logic regw, input logic memw,
                                 input string tag);
        comb_exp_t ce;
        flag_exp_t fe;
        logic      cx;
        logic      gate;
        @(negedge clk);
        reset_n  = rn;
        En       = en;
        Cond     = cond;
        ALUFlags = alu;
        FlagW    = fw;
        PCS      = pcs;
        RegW     = regw;
        MemW     = memw;

        cx   = modelCond(cond, modelFlags);
        gate = rn & en & cx;
        ce.tag      = tag;
        ce.checkCx  = modelValid;
        ce.cx       = cx;
        ce.pcsrc    = gate & pcs;
        ce.regwrite = gate & regw;
        ce.memwrite = gate & memw;
        combQ.push_back(ce);

        if (!rn) begin
            modelFlags = 4'b0000;
            modelValid = 1'b1;
        end else if (gate === 1'b1) begin
            if (fw[1] === 1'b1) modelFlags[3:2] = alu[3:2];
            if (fw[0] === 1'b1) modelFlags[1:0] = alu[1:0];
        end
        fe.tag   = tag;
        fe.flags = modelFlags;
        flagQ.push_back(fe);

        #2;
        ce = combQ.pop_front();
        if (ce.checkCx) checkOutput({ce.tag, ".CondEx"}, {3'b000, CondEx}, {3'b000, ce.cx});
        checkOutput({ce.tag, ".PCSrc"},    {3'b000, PCSrc},    {3'b000, ce.pcsrc});
        checkOutput({ce.tag, ".RegWrite"}, {3'b000, RegWrite}, {3'b000, ce.regwrite});
        checkOutput({ce.tag, ".MemWrite"}, {3'b000, MemWrite}, {3'b000, ce.memwrite});

        @(posedge clk);
        #1;
        fe = flagQ.pop_front();
        checkOutput({fe.tag, ".Flags"}, Flags, fe.flags);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset_n  = 1'b0;
        En       = 1'b0;
        Cond     = 4'b0000;
        ALUFlags = 4'b0000;
        FlagW    = 2'b00;
        PCS      = 1'b0;
        RegW     = 1'b0;
        MemW     = 1'b0;

        // Reset overrides a simultaneous flag write and gates all writes.
        applyStimulus(0, 1, 4'b1110, 4'b1111, 2'b11, 1, 1, 1, "rst0");
        applyStimulus(0, 1, 4'b1110, 4'b1111, 2'b11, 1, 1, 1, "rst1");
        checkOutput("rst.flagsZero", Flags, 4'b0000);
        applyStimulus(1, 0, 4'b0001, 4'b0000, 2'b00, 0, 0, 0, "postRstNE");
        checkOutput("postRstNE.CondEx", {3'b000, CondEx}, 4'b0001);
        applyStimulus(1, 0, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, "postRstEQ");
        applyStimulus(1, 0, 4'b1010, 4'b0000, 2'b00, 0, 0, 0, "postRstGE");
        applyStimulus(1, 0, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, "postRstAL");

        // CMP setting Z, then a BEQ that must take the branch.
        applyStimulus(1, 1, 4'b1110, 4'b0110, 2'b11, 0, 0, 0, "cmp");
        checkOutput("cmp.flagsConst", Flags, 4'b0110);
        applyStimulus(1, 1, 4'b0000, 4'b0000, 2'b00, 1, 0, 0, "beq");

        // Failed NE with Z set: no writes and no flag update.
        applyStimulus(1, 1, 4'b1110, 4'b0100, 2'b11, 0, 0, 0, "setZ");
        applyStimulus(1, 1, 4'b0001, 4'b1111, 2'b11, 0, 1, 1, "failNE");
        checkOutput("failNE.flagsConst", Flags, 4'b0100);

        // Independent flag groups.
        applyStimulus(0, 0, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, "rstSplit");
        applyStimulus(1, 1, 4'b1110, 4'b1111, 2'b10, 0, 0, 0, "splitNZ");
        checkOutput("splitNZ.flagsConst", Flags, 4'b1100);
        applyStimulus(1, 1, 4'b1110, 4'b0000, 2'b01, 0, 0, 0, "splitCV");
        checkOutput("splitCV.flagsConst", Flags, 4'b1100);

        // Signed and unsigned compare conditions.
        applyStimulus(1, 1, 4'b1110, 4'b1000, 2'b11, 0, 0, 0, "set1000");
        applyStimulus(1, 0, 4'b1011, 4'b0000, 2'b00, 0, 0, 0, "LT1000");
        checkOutput("LT1000.CondEx", {3'b000, CondEx}, 4'b0001);
        applyStimulus(1, 0, 4'b1010, 4'b0000, 2'b00, 0, 0, 0, "GE1000");
        applyStimulus(1, 0, 4'b1100, 4'b0000, 2'b00, 0, 0, 0, "GT1000");
        applyStimulus(1, 0, 4'b1101, 4'b0000, 2'b00, 0, 0, 0, "LE1000");
        applyStimulus(1, 1, 4'b1110, 4'b1001, 2'b11, 0, 0, 0, "set1001");
        applyStimulus(1, 0, 4'b1010, 4'b0000, 2'b00, 0, 0, 0, "GE1001");
        applyStimulus(1, 0, 4'b1100, 4'b0000, 2'b00, 0, 0, 0, "GT1001");
        applyStimulus(1, 1, 4'b1110, 4'b0010, 2'b11, 0, 0, 0, "set0010");
        applyStimulus(1, 0, 4'b1000, 4'b0000, 2'b00, 0, 0, 0, "HI0010");
        checkOutput("HI0010.CondEx", {3'b000, CondEx}, 4'b0001);
        applyStimulus(1, 0, 4'b1001, 4'b0000, 2'b00, 0, 0, 0, "LS0010");

        // Stall holds flags, including with an undriven FlagW.
        applyStimulus(1, 0, 4'b1110, 4'b1111, 2'b11, 0, 1, 0, "stall");
        checkOutput("stall.flagsConst", Flags, 4'b0010);
        applyStimulus(1, 0, 4'b1110, 4'b1111, 2'bxx, 0, 1, 0, "stallX");
        applyStimulus(1, 1, 4'b1110, 4'b1111, 2'b11, 0, 1, 0, "resume");
        checkOutput("resume.flagsConst", Flags, 4'b1111);

        // Reset arriving on an in-flight flag-setting instruction.
        applyStimulus(0, 1, 4'b1110, 4'b1010, 2'b11, 1, 1, 1, "midRst");
        checkOutput("midRst.flagsConst", Flags, 4'b0000);

        // Every condition against every flag combination.
        for (int f = 0; f < 16; f++) begin
            applyStimulus(1, 1, 4'b1110, 4'(f), 2'b11, 0, 0, 0, $sformatf("load f=%0d", f));
            for (int c = 0; c < 16; c++) begin
                applyStimulus(1, 0, 4'(c), 4'(15 - f), 2'b11, 1, 1, 1,
                              $sformatf("sweep c=%0d f=%0d", c, f));
            end
        end

        // Random traffic with occasional resets and stalls.
        for (int i = 0; i < 80; i++) begin
            applyStimulus(logic'($urandom_range(0, 11) != 0), logic'($urandom_range(0, 3) != 0),
                          4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                          2'($urandom_range(0, 3)), logic'($urandom_range(0, 1)),
                          logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
                          $sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
